// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_elastic
// Description : Cascaded valid/ready register stages (plain or skid-buffered)
//               with synchronous flush and an occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_elastic #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1,
    parameter int SKID   = 0,
    parameter int CNT_W  = $clog2(STAGES * (1 + SKID) + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             pin_valid,
    output logic             pin_ready,
    input  logic [WIDTH-1:0] pin_data,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic [WIDTH-1:0] pout_data,
    output logic [CNT_W-1:0] occupancy
);

    logic             w_drop;
    logic             w_pin_xfer;
    logic             w_pout_xfer;
    logic [CNT_W-1:0] r_occ;

    assign w_drop = rst | flush;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             w_in_valid;
        logic             w_in_ready;
        logic [WIDTH-1:0] w_in_data;
        logic             w_out_valid;
        logic             w_out_ready;
        logic [WIDTH-1:0] w_out_data;

        if (k == 0) begin : g_head
            assign w_in_valid = pin_valid;
            assign w_in_data  = pin_data;
        end else begin : g_link
            assign w_in_valid = g_stage[k-1].w_out_valid;
            assign w_in_data  = g_stage[k-1].w_out_data;
        end

        if (k == STAGES - 1) begin : g_tail
            assign w_out_ready = pout_ready;
        end else begin : g_next
            assign w_out_ready = g_stage[k+1].w_in_ready;
        end

        if (SKID == 0) begin : g_pipe
            logic             r_valid;
            logic [WIDTH-1:0] r_data;
            logic             w_in_xfer;

            assign w_in_ready = ~r_valid | w_out_ready;
            assign w_in_xfer  = w_in_valid & w_in_ready;

            always_ff @(posedge clk) begin
                if (w_drop) begin
                    r_valid <= 1'b0;
                end else if (w_in_xfer) begin
                    r_valid <= 1'b1;
                end else if (w_out_ready) begin
                    r_valid <= 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (w_in_xfer) begin
                    r_data <= w_in_data;
                end
            end

            assign w_out_valid = r_valid;
            assign w_out_data  = r_data;
        end else begin : g_skid
            logic             r_main_valid;
            logic             r_skid_valid;
            logic [WIDTH-1:0] r_main_data;
            logic [WIDTH-1:0] r_skid_data;
            logic             w_in_xfer;
            logic             w_out_xfer;

            // Ready comes straight from a flop: no path from downstream ready.
            assign w_in_ready = ~r_skid_valid;
            assign w_in_xfer  = w_in_valid & ~r_skid_valid;
            assign w_out_xfer = r_main_valid & w_out_ready;

            always_ff @(posedge clk) begin
                if (w_drop) begin
                    r_main_valid <= 1'b0;
                    r_skid_valid <= 1'b0;
                end else if (w_out_xfer) begin
                    r_main_valid <= r_skid_valid | w_in_xfer;
                    r_skid_valid <= 1'b0;
                end else if (w_in_xfer) begin
                    if (r_main_valid) begin
                        r_skid_valid <= 1'b1;
                    end else begin
                        r_main_valid <= 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (w_out_xfer) begin
                    if (r_skid_valid) begin
                        r_main_data <= r_skid_data;
                    end else if (w_in_xfer) begin
                        r_main_data <= w_in_data;
                    end
                end else if (w_in_xfer) begin
                    if (r_main_valid) begin
                        r_skid_data <= w_in_data;
                    end else begin
                        r_main_data <= w_in_data;
                    end
                end
            end

            assign w_out_valid = r_main_valid;
            assign w_out_data  = r_main_data;
        end
    end

    // Boundary handshakes are masked during rst/flush so nothing moves.
    assign pin_ready  = g_stage[0].w_in_ready & ~w_drop;
    assign pout_valid = g_stage[STAGES-1].w_out_valid & ~w_drop;
    assign pout_data  = g_stage[STAGES-1].w_out_data;

    assign w_pin_xfer  = pin_valid & pin_ready;
    assign w_pout_xfer = pout_valid & pout_ready;

    always_ff @(posedge clk) begin
        if (w_drop) begin
            r_occ <= '0;
        end else if (w_pin_xfer & ~w_pout_xfer) begin
            r_occ <= r_occ + CNT_W'(1);
        end else if (~w_pin_xfer & w_pout_xfer) begin
            r_occ <= r_occ - CNT_W'(1);
        end
    end

    assign occupancy = r_occ;

endmodule
`default_nettype wire
